// File: rtl/alarma_anunciador.sv
// Alarm annunciator: debounces an alarm condition while armed, then blinks a siren
// until acknowledged, escalating to a steady siren if the operator does not respond.
module alarma_anunciador #(
    parameter int DEB_CYC   = 4,
    parameter int BLINK_DIV = 8,
    parameter int ESC_CYC   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       alarm_in,
    input  logic       ack,
    output logic       siren,
    output logic       lamp,
    output logic       escalate,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        ALERT    = 2'b10,
        ESCAL    = 2'b11
    } stateT;

    // Each counter holds 0..LIMIT-1 and is compared against its terminal value, so it never wraps.
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int EW = $clog2(ESC_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [EW-1:0] ESC_LAST   = EW'(ESC_CYC - 1);

    stateT          curState;
    logic [DW-1:0]  debCnt;
    logic [BW-1:0]  blinkCnt;
    logic [EW-1:0]  escCnt;

    assign state = curState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= DISARMED;
            debCnt   <= '0;
            blinkCnt <= '0;
            escCnt   <= '0;
            siren    <= 1'b0;
            lamp     <= 1'b0;
            escalate <= 1'b0;
        end else begin
            case (curState)
                DISARMED: begin
                    debCnt <= '0;
                    if (arm) curState <= ARMED;
                end

                ARMED: begin
                    if (!arm) begin
                        // Disarming outranks a trigger landing on the same edge.
                        curState <= DISARMED;
                        debCnt   <= '0;
                    end else if (alarm_in) begin
                        if (debCnt == DEB_LAST) begin
                            curState <= ALERT;
                            debCnt   <= '0;
                            blinkCnt <= '0;
                            escCnt   <= '0;
                            siren    <= 1'b1;
                            lamp     <= 1'b1;
                            escalate <= 1'b0;
                        end else begin
                            debCnt <= debCnt + DW'(1);
                        end
                    end else begin
                        debCnt <= '0;
                    end
                end

                ALERT: begin
                    if (ack) begin
                        curState <= ARMED;
                        debCnt   <= '0;
                        siren    <= 1'b0;
                        lamp     <= 1'b0;
                        escalate <= 1'b0;
                    end else if (escCnt == ESC_LAST) begin
                        curState <= ESCAL;
                        siren    <= 1'b1;
                        lamp     <= 1'b1;
                        escalate <= 1'b1;
                    end else begin
                        escCnt <= escCnt + EW'(1);
                        // Siren toggles every BLINK_DIV cycles, starting high on entry.
                        if (blinkCnt == BLINK_LAST) begin
                            blinkCnt <= '0;
                            siren    <= ~siren;
                        end else begin
                            blinkCnt <= blinkCnt + BW'(1);
                        end
                    end
                end

                ESCAL: begin
                    if (ack) begin
                        curState <= ARMED;
                        debCnt   <= '0;
                        siren    <= 1'b0;
                        lamp     <= 1'b0;
                        escalate <= 1'b0;
                    end
                end

                default: begin
                    curState <= DISARMED;
                    siren    <= 1'b0;
                    lamp     <= 1'b0;
                    escalate <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarma_anunciador.sv
// Scoreboard bench for alarma_anunciador at default parameters: stimulus pushes the
// expected {state,siren,lamp,escalate} per edge; a monitor pops and compares.
module tb_alarma_anunciador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       alarm_in = 1'b0;
    logic       ack = 1'b0;
    logic       siren, lamp, escalate;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [4:0] exp;   // {state[1:0], siren, lamp, escalate}
    } expT;

    expT  sbq[$];
    event checkNow;

    alarma_anunciador dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .alarm_in (alarm_in),
        .ack      (ack),
        .siren    (siren),
        .lamp     (lamp),
        .escalate (escalate),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Monitor: compares one queued expectation after each rising edge or on request.
    initial begin
        forever begin
            @(posedge clk or checkNow);
            #1;
            if (sbq.size() > 0) begin
                expT        e;
                logic [4:0] act;
                e   = sbq.pop_front();
                act = {state, siren, lamp, escalate};
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got st=%b sir=%b lmp=%b esc=%b, expected st=%b sir=%b lmp=%b esc=%b",
                             e.name, act[4:3], act[2], act[1], act[0],
                             e.exp[4:3], e.exp[2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    // Apply inputs for one edge and record what the outputs must be after it.
    task automatic step(input logic a, input logic al, input logic ak,
                        input string nm, input logic [4:0] exp);
        expT e;
        @(negedge clk);
        arm      = a;
        alarm_in = al;
        ack      = ak;
        e.name   = nm;
        e.exp    = exp;
        sbq.push_back(e);
    endtask

    // ALERT cycle k (k edges after entry): siren high in blocks 0-7, 16-23, low in 8-15, 24-31.
    function automatic logic [4:0] alertExp(input int k);
        logic sir;
        sir = ((k / 8) % 2) == 0;
        return {2'b10, sir, 1'b1, 1'b0};
    endfunction

    task automatic alertHold(input int edges, input logic a, input string nm);
        for (int k = 1; k <= edges; k++) begin
            if (k == 32) step(a, 1'b0, 1'b0, {nm, "_esc"}, 5'b11111);
            else         step(a, 1'b0, 1'b0, $sformatf("%s_k%0d", nm, k), alertExp(k));
        end
    endtask

    task automatic asyncReset(input string nm);
        expT e;
        @(negedge clk);
        arm = 1'b0;
        ack = 1'b0;
        alarm_in = 1'b0;
        #2;
        rst_n  = 1'b0;
        e.name = nm;
        e.exp  = 5'b00000;
        sbq.push_back(e);
        ->checkNow;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        expT e;
        // Reset state, checked while reset is held and before any edge.
        #2;
        e.name = "reset_init";
        e.exp  = 5'b00000;
        sbq.push_back(e);
        ->checkNow;
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 0, "disarmed_hold", 5'b00000);
        step(1, 0, 0, "arm", 5'b01000);

        // Three-edge glitch must not trigger.
        step(1, 1, 0, "deb1", 5'b01000);
        step(1, 1, 0, "deb2", 5'b01000);
        step(1, 1, 0, "deb3", 5'b01000);
        step(1, 0, 0, "deb_clear", 5'b01000);
        step(1, 1, 0, "deb1b", 5'b01000);
        step(1, 1, 0, "deb2b", 5'b01000);
        step(1, 1, 0, "deb3b", 5'b01000);
        step(1, 1, 0, "trigger", 5'b10110);

        // Full blink pattern into escalation; arm dropped partway is ignored.
        alertHold(19, 1'b1, "blinkA");
        for (int k = 20; k <= 32; k++) begin
            if (k == 32) step(0, 0, 0, "esc_enter", 5'b11111);
            else         step(0, 0, 0, $sformatf("blinkA_noarm_k%0d", k), alertExp(k));
        end

        step(0, 0, 0, "escal_ignore_arm1", 5'b11111);
        step(0, 1, 0, "escal_ignore_arm2", 5'b11111);
        step(1, 1, 1, "escal_ack", 5'b01000);

        // Persistent alarm retriggers after the full debounce.
        step(1, 1, 0, "retrig1", 5'b01000);
        step(1, 1, 0, "retrig2", 5'b01000);
        step(1, 1, 0, "retrig3", 5'b01000);
        step(1, 1, 0, "retrig4", 5'b10110);

        step(1, 1, 1, "alert_ack", 5'b01000);
        step(1, 1, 0, "reack1", 5'b01000);
        step(1, 1, 0, "reack2", 5'b01000);
        step(1, 1, 0, "reack3", 5'b01000);
        step(1, 1, 0, "reack4", 5'b10110);

        // ack on the escalation edge wins.
        alertHold(31, 1'b1, "blinkB");
        step(1, 0, 1, "ack_vs_esc", 5'b01000);

        // arm=0 on the 4th debounce edge wins.
        step(1, 1, 0, "disdeb1", 5'b01000);
        step(1, 1, 0, "disdeb2", 5'b01000);
        step(1, 1, 0, "disdeb3", 5'b01000);
        step(0, 1, 0, "disarm_vs_trig", 5'b00000);
        step(0, 1, 0, "disarm_hold", 5'b00000);

        // Reach ESCAL again, then reset asynchronously between edges.
        step(1, 0, 0, "rearm", 5'b01000);
        step(1, 1, 0, "escC_deb1", 5'b01000);
        step(1, 1, 0, "escC_deb2", 5'b01000);
        step(1, 1, 0, "escC_deb3", 5'b01000);
        step(1, 1, 0, "escC_trig", 5'b10110);
        alertHold(32, 1'b1, "blinkC");
        asyncReset("reset_escal");

        step(0, 0, 0, "post_reset_hold", 5'b00000);
        step(1, 0, 0, "post_reset_arm", 5'b01000);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
